// File: rtl/nand_target_responder_pkg.sv
// Shared opcodes, FSM encoding and status-byte layout for the NAND target model.
package nand_target_responder_pkg;

  localparam logic [7:0] OPC_READ      = 8'h00;
  localparam logic [7:0] OPC_READ_CONF = 8'h30;
  localparam logic [7:0] OPC_PROG      = 8'h80;
  localparam logic [7:0] OPC_PROG_CONF = 8'h10;
  localparam logic [7:0] OPC_READ_ID   = 8'h90;
  localparam logic [7:0] OPC_STATUS    = 8'h70;
  localparam logic [7:0] OPC_RESET     = 8'hFF;

  // Busy time modelled for the FFh reset command.
  localparam int unsigned RST_BUSY_CYCLES = 8;

  // Status byte bit positions.
  localparam int ST_BIT_WP   = 7;
  localparam int ST_BIT_RDY  = 6;
  localparam int ST_BIT_ARDY = 5;
  localparam int ST_BIT_FAIL = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD_BUSY,
    ST_RD_OUT,
    ST_PG_DATA,
    ST_PG_BUSY,
    ST_ID_OUT,
    ST_ST_OUT,
    ST_RST_BUSY
  } state_e;

  // Which command opened the current address phase.
  typedef enum logic [1:0] {
    OP_READ,
    OP_PROG,
    OP_ID
  } op_e;

endpackage

// File: rtl/nand_target_responder_if.sv
// Pin-level NAND bus between a flash controller (master) and the target model (slave).
interface nand_target_responder_if;
  logic       iNAND_CE;
  logic       iNAND_CLE;
  logic       iNAND_ALE;
  logic       iNAND_WE;
  logic       iNAND_RE;
  logic       iNAND_WP;
  logic [7:0] iNAND_DQ;
  logic [7:0] oNAND_DQ;
  logic       oNAND_DQOutEnable;
  logic       oNAND_RB;
  logic       oProtocolError;

  modport master (
    output iNAND_CE, iNAND_CLE, iNAND_ALE, iNAND_WE, iNAND_RE, iNAND_WP, iNAND_DQ,
    input  oNAND_DQ, oNAND_DQOutEnable, oNAND_RB, oProtocolError
  );

  modport slave (
    input  iNAND_CE, iNAND_CLE, iNAND_ALE, iNAND_WE, iNAND_RE, iNAND_WP, iNAND_DQ,
    output oNAND_DQ, oNAND_DQOutEnable, oNAND_RB, oProtocolError
  );
endinterface

// File: rtl/nand_pin_sync.sv
// Two-flop synchronizer with edge detect on the synchronized value.
module nand_pin_sync #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  // Synchronizer chain plus one history stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/nand_target_responder.sv
// Device-side ONFI SDR NAND target: decodes the strobes, runs a command
// subset against an internal page RAM and drives DQ and R/B#.
module nand_target_responder
  import nand_target_responder_pkg::*;
#(
  parameter int unsigned PageBytes      = 64,
  parameter int unsigned NumPages       = 16,
  parameter int unsigned ReadBusyCycles = 32,
  parameter int unsigned ProgBusyCycles = 64,
  parameter logic [39:0] IdBytes        = 40'h00_A6_90_D3_2C
) (
  input  logic              iSystemClock,
  input  logic              iReset,
  nand_target_responder_if.slave bus
);
  localparam int CW = $clog2(PageBytes) + 1;  // column counter, MSB flags out-of-page
  localparam int PW = $clog2(NumPages);
  localparam int AW = PW + CW - 1;

  logic we_q, we_rise, we_fall;
  logic re_q, re_rise, re_fall;
  logic ce_q, ce_rise, ce_fall;
  logic [10:0] aux_q, aux_rise, aux_fall;

  nand_pin_sync #(.W(1), .RST_VAL(1'b1)) u_sync_we (
    .clk_i(iSystemClock), .rst_ni(iReset), .d_i(bus.iNAND_WE),
    .q_o(we_q), .rise_o(we_rise), .fall_o(we_fall));
  nand_pin_sync #(.W(1), .RST_VAL(1'b1)) u_sync_re (
    .clk_i(iSystemClock), .rst_ni(iReset), .d_i(bus.iNAND_RE),
    .q_o(re_q), .rise_o(re_rise), .fall_o(re_fall));
  nand_pin_sync #(.W(1), .RST_VAL(1'b1)) u_sync_ce (
    .clk_i(iSystemClock), .rst_ni(iReset), .d_i(bus.iNAND_CE),
    .q_o(ce_q), .rise_o(ce_rise), .fall_o(ce_fall));
  // Level signals and DQ get the same depth so they line up with the strobe edges.
  nand_pin_sync #(.W(11), .RST_VAL(11'd0)) u_sync_aux (
    .clk_i(iSystemClock), .rst_ni(iReset),
    .d_i({bus.iNAND_WP, bus.iNAND_CLE, bus.iNAND_ALE, bus.iNAND_DQ}),
    .q_o(aux_q), .rise_o(aux_rise), .fall_o(aux_fall));

  logic unused_edges;
  assign unused_edges = ^{we_q, we_fall, re_q, re_rise, ce_fall, aux_rise, aux_fall};

  logic       aux_wp, aux_cle, aux_ale;
  logic [7:0] aux_dq;
  assign aux_wp  = aux_q[10];
  assign aux_cle = aux_q[9];
  assign aux_ale = aux_q[8];
  assign aux_dq  = aux_q[7:0];

  logic we_ev, re_ev;
  assign we_ev = we_rise & ~ce_q;
  assign re_ev = re_fall & ~ce_q;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [2:0]    addr_cnt_q, addr_cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [PW-1:0] page_q, page_d;
  logic [2:0]    id_idx_q, id_idx_d;
  logic [15:0]   busy_cnt_q, busy_cnt_d;
  logic          fail_q, fail_d, perr_q, perr_d, oe_q, oe_d;
  logic [7:0]    dq_q, dq_d;
  logic          pend_q, pend_d, pend_ram_q, pend_ram_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic          mem_we, busy;
  logic [7:0]    status_byte, rd_data_q;
  logic [AW-1:0] ram_addr;
  logic [7:0]    page_mem [NumPages*PageBytes];

  assign busy     = (busy_cnt_q != 16'd0);
  assign ram_addr = {page_q, col_q[CW-2:0]};

  // Single-port page store; read and write share the current page/column.
  always_ff @(posedge iSystemClock) begin
    if (mem_we) page_mem[ram_addr] <= aux_dq;
    rd_data_q <= page_mem[ram_addr];
  end

  // Status byte assembled from live WP#, busy and the program FAIL flag.
  always_comb begin
    status_byte              = '0;
    status_byte[ST_BIT_WP]   = aux_wp;
    status_byte[ST_BIT_RDY]  = ~busy;
    status_byte[ST_BIT_ARDY] = ~busy;
    status_byte[ST_BIT_FAIL] = fail_q;
  end

  // Protocol state and output registers.
  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      addr_cnt_q  <= '0;
      col_q       <= '0;
      page_q      <= '0;
      id_idx_q    <= '0;
      busy_cnt_q  <= '0;
      fail_q      <= 1'b0;
      perr_q      <= 1'b0;
      oe_q        <= 1'b0;
      dq_q        <= 8'h00;
      pend_q      <= 1'b0;
      pend_ram_q  <= 1'b0;
      pend_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_cnt_q  <= addr_cnt_d;
      col_q       <= col_d;
      page_q      <= page_d;
      id_idx_q    <= id_idx_d;
      busy_cnt_q  <= busy_cnt_d;
      fail_q      <= fail_d;
      perr_q      <= perr_d;
      oe_q        <= oe_d;
      dq_q        <= dq_d;
      pend_q      <= pend_d;
      pend_ram_q  <= pend_ram_d;
      pend_byte_q <= pend_byte_d;
    end
  end

  // Next-state: busy countdown, output pipeline, then strobe decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_cnt_d  = addr_cnt_q;
    col_d       = col_q;
    page_d      = page_q;
    id_idx_d    = id_idx_q;
    busy_cnt_d  = busy_cnt_q;
    fail_d      = fail_q;
    perr_d      = perr_q;
    oe_d        = oe_q;
    dq_d        = dq_q;
    pend_d      = 1'b0;
    pend_ram_d  = pend_ram_q;
    pend_byte_d = pend_byte_q;
    mem_we      = 1'b0;

    if (busy) begin
      busy_cnt_d = busy_cnt_q - 16'd1;
      // A status read during busy leaves the FSM in ST_OUT; only the owning state advances.
      if (busy_cnt_q == 16'd1) begin
        case (state_q)
          ST_RD_BUSY:             state_d = ST_RD_OUT;
          ST_PG_BUSY, ST_RST_BUSY: state_d = ST_IDLE;
          default: ;
        endcase
      end
    end

    // Second output stage: RAM data has been registered one cycle earlier.
    if (pend_q) begin
      dq_d = pend_ram_q ? rd_data_q : pend_byte_q;
      oe_d = 1'b1;
    end

    if (ce_rise) begin
      oe_d = 1'b0;
      if (!(state_q inside {ST_RD_BUSY, ST_PG_BUSY, ST_RST_BUSY})) state_d = ST_IDLE;
    end else if (we_ev) begin
      if (aux_cle && aux_ale) begin
        perr_d = 1'b1;
      end else if (aux_cle) begin
        oe_d = 1'b0;
        if (aux_dq == OPC_RESET) begin
          state_d    = ST_RST_BUSY;
          busy_cnt_d = 16'(RST_BUSY_CYCLES);
          perr_d     = 1'b0;
        end else if (aux_dq == OPC_STATUS) begin
          state_d = ST_ST_OUT;
        end else if (busy) begin
          perr_d = 1'b1;
        end else begin
          case (aux_dq)
            OPC_READ, OPC_PROG, OPC_READ_ID: begin
              state_d    = ST_ADDR;
              addr_cnt_d = '0;
              op_d       = (aux_dq == OPC_READ) ? OP_READ :
                           (aux_dq == OPC_PROG) ? OP_PROG : OP_ID;
              if (aux_dq == OPC_PROG) fail_d = 1'b0;
            end
            OPC_READ_CONF: begin
              if (state_q == ST_ADDR && op_q == OP_READ && addr_cnt_q == 3'd5) begin
                state_d    = ST_RD_BUSY;
                busy_cnt_d = 16'(ReadBusyCycles);
              end else begin
                state_d = ST_IDLE;
                perr_d  = 1'b1;
              end
            end
            OPC_PROG_CONF: begin
              if (state_q == ST_PG_DATA) begin
                state_d    = ST_PG_BUSY;
                busy_cnt_d = 16'(ProgBusyCycles);
                if (!aux_wp) fail_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
                perr_d  = 1'b1;
              end
            end
            default: begin
              state_d = ST_IDLE;
              perr_d  = 1'b1;
            end
          endcase
        end
      end else if (aux_ale) begin
        if (state_q == ST_ADDR) begin
          if (op_q == OP_ID) begin
            state_d  = ST_ID_OUT;
            id_idx_d = '0;
          end else begin
            case (addr_cnt_q)
              3'd0: col_d = (32'(aux_dq) >= PageBytes) ? CW'(PageBytes) : CW'(aux_dq);
              3'd1: if (aux_dq != 8'h00) col_d = CW'(PageBytes);
              3'd2: page_d = aux_dq[PW-1:0];
              default: ;
            endcase
            if (addr_cnt_q != 3'd5) addr_cnt_d = addr_cnt_q + 3'd1;
            if (op_q == OP_PROG && addr_cnt_q == 3'd4) state_d = ST_PG_DATA;
          end
        end
      end else if (state_q == ST_PG_DATA) begin
        // Writes past the page end, or with WP# asserted, are dropped.
        mem_we = ~col_q[CW-1] & aux_wp;
        if (!col_q[CW-1]) col_d = col_q + CW'(1);
      end
    end else if (re_ev) begin
      if (busy && state_q != ST_ST_OUT) begin
        pend_d      = 1'b1;
        pend_ram_d  = 1'b0;
        pend_byte_d = 8'hFF;
        perr_d      = 1'b1;
      end else begin
        case (state_q)
          ST_RD_OUT: begin
            pend_d      = 1'b1;
            pend_ram_d  = ~col_q[CW-1];
            pend_byte_d = 8'hFF;
            if (!col_q[CW-1]) col_d = col_q + CW'(1);
          end
          ST_ID_OUT: begin
            pend_d      = 1'b1;
            pend_ram_d  = 1'b0;
            pend_byte_d = IdBytes[{id_idx_q, 3'b000} +: 8];
            if (id_idx_q != 3'd4) id_idx_d = id_idx_q + 3'd1;
          end
          ST_ST_OUT: begin
            pend_d      = 1'b1;
            pend_ram_d  = 1'b0;
            pend_byte_d = status_byte;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.oNAND_DQ          = dq_q;
  assign bus.oNAND_DQOutEnable = oe_q;
  assign bus.oNAND_RB          = ~busy;
  assign bus.oProtocolError    = perr_q;
endmodule

// File: doc/nand_target_responder.md
# nand_target_responder

Synthesizable ONFI SDR (asynchronous-mode) NAND target that answers the controller's pin-level bus from the device side: it decodes CE#/CLE/ALE/WE#/RE#, executes a command subset against an internal page store, and drives DQ and R/B#. It attaches directly to the physical pins of the flash controller for loopback bring-up and closed-loop regression without a real flash part.

## Interface
- PageBytes, 64: bytes per page (power of two, ≥ 4).
- NumPages, 16: pages in the internal store (power of two).
- ReadBusyCycles, 32: iSystemClock cycles R/B# stays low after 30h.
- ProgBusyCycles, 64: cycles R/B# stays low after 10h.
- IdBytes, 40'h00_A6_90_D3_2C: READ ID response, byte 0 in bits [7:0].

- iSystemClock in 1: single clock; every pin is sampled and driven on its rising edge.
- iReset in 1: reset, asynchronous assert, active-low.
- iNAND_CE in 1: chip enable, active-low.
- iNAND_CLE in 1: command latch enable.
- iNAND_ALE in 1: address latch enable.
- iNAND_WE in 1: write enable, active-low; data is latched on its rising edge.
- iNAND_RE in 1: read enable, active-low; the next byte is presented on its falling edge.
- iNAND_WP in 1: write protect, active-low.
- iNAND_DQ in 8: DQ bus as driven by the host.
- oNAND_DQ out 8: DQ value when this block is driving.
- oNAND_DQOutEnable out 1: enables the DQ tri-state driver.
- oNAND_RB out 1: ready/busy, 0 = busy.
- oProtocolError out 1: sticky; cleared by reset or a FFh command.

## Operation
- All pin inputs pass through 2-flop synchronizers, and DQ goes through the same depth so it stays aligned with the strobes. Strobe edges are detected on the synchronized signals only.
- While CE# is high, WE#/RE# edges are ignored and oNAND_DQOutEnable is 0. A CE# rise in the middle of a sequence returns the FSM to IDLE. A running busy countdown continues and its command still completes.
- WE# rise with CLE=1, ALE=0: command byte. With ALE=1, CLE=0: address byte. With both 0: data byte. With both 1: oProtocolError is set and the byte is ignored.
- States:
  - IDLE
  - ADDR (collecting address bytes)
  - RD_BUSY
  - RD_OUT
  - PG_DATA
  - PG_BUSY
  - ID_OUT
  - ST_OUT
  - RST_BUSY
- Commands:
  - 00h: enter ADDR, which expects 5 bytes: col lo, col hi, row0, row1, row2. Page index = row[log2(NumPages)-1:0]. 30h after all 5 bytes → RD_BUSY, then RD_OUT.
  - 80h: ADDR, then PG_DATA. Each data byte is written at col, then col increments. 10h → PG_BUSY.
  - 90h: takes 1 address byte (value ignored), then ID_OUT.
  - 70h: ST_OUT. Accepted in every state, including busy.
  - FFh: abort any operation and enter RST_BUSY for 8 cycles.
  - Any other opcode, or 30h/10h without a complete address: oProtocolError is set, FSM returns to IDLE.
  - Any non-70h/FFh command while busy: oProtocolError is set, the command is ignored.
- Status byte: bit7 = iNAND_WP, bit6 = bit5 = ~busy, bit0 = FAIL, all other bits 0.
- FAIL is set when a 10h is issued with WP#=0; in that case the page is not written. FAIL clears on the next 80h.
- Column counter:
  - Width is log2(PageBytes)+1.
  - Reads at col ≥ PageBytes return FFh. Writes at col ≥ PageBytes are dropped. The counter saturates and does not wrap.
  - ID_OUT index saturates at 4 and keeps returning byte 4.
  - ST_OUT repeats the status byte on every RE#.
- The page store is an inferred single-port RAM of NumPages×PageBytes bytes. Its contents after power-up are undefined.
- Program writes go directly to RAM in PG_DATA; PG_BUSY only models tPROG.

## Timing
- Reset values: oNAND_DQ = 00h, oNAND_DQOutEnable = 0, oNAND_RB = 1, oProtocolError = 0, FSM = IDLE.
- WE# rise at pin → byte acted on 3 cycles later (2 synchronizer + 1 edge detect).
- RE# fall at pin → oNAND_DQ and oNAND_DQOutEnable update 4 cycles later (one extra cycle for the RAM read). The host must hold tRP/tREH ≥ 6 cycles and tWP/tWH ≥ 3 cycles.
- oNAND_DQOutEnable rises on the first RE# fall in an output state. It falls 3 cycles after a CE# rise, or on any command byte.
- oNAND_RB falls in the cycle after the 30h/10h/FFh byte is acted on. It stays low for exactly the parameterized count, then rises.
- A RE# fall while busy (other than in ST_OUT) drives FFh and sets oProtocolError.

## Structure
- Shared package: opcode constants (00h, 30h, 80h, 10h, 90h, 70h, FFh), the FSM state enum, and status bit positions.
- One sub-module, nand_pin_sync: a parameterized 2-flop synchronizer with rise/fall detect, instantiated for WE#, RE#, and CE#, and also used for CLE/ALE/DQ delay alignment.

## Test plan
- Reset: release iReset → oNAND_RB = 1, oNAND_DQOutEnable = 0, and 70h followed by RE# returns 0xE0 with WP#=1.
- READ ID: 90h, addr 00h, 5 RE# pulses → 2C, D3, 90, A6, 00; a 6th pulse returns 00.
- Program then read:
  - 80h, addr 00 00 03 00 00, data 11h..18h, 10h → R/B# low for 64 cycles.
  - 00h, same address, 30h → R/B# low for 32 cycles; 8 RE# pulses return 11h..18h.
- Column boundary: read at col PageBytes-2 → last two bytes, then FFh, FFh.
- Write protect: WP#=0, program page 5 → status byte = 0x61, and a subsequent read of page 5 is unchanged.
- Abort and errors:
  - CE# high mid-address, then 70h → IDLE, no error.
  - 10h with no prior address → oProtocolError = 1.
  - FFh → R/B# low for 8 cycles and oProtocolError = 0.
